// File: rtl/spi_sts_event_sched.sv
// Serializes rising edges of the synchronized SPI status vectors into one-byte
// fault events via a round-robin scheduler; keeps sticky per-type summaries.
module spi_sts_event_sched #(
    parameter int unsigned DROP_CNT_W  = 16,
    parameter bit          SPI_OFF_EVT = 1'b1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  spi_off_stable,
    input  logic [7:0]            over_thresh_stable,
    input  logic [7:0]            thresh_underflow_stable,
    input  logic [7:0]            thresh_overflow_stable,
    input  logic [7:0]            dac_buf_underflow_stable,
    input  logic [7:0]            adc_buf_overflow_stable,
    input  logic [7:0]            unexp_dac_trig_stable,
    input  logic [7:0]            unexp_adc_trig_stable,
    input  logic                  clr,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [7:0]            evt_data,
    output logic [6:0]            fault_sticky,
    output logic                  any_fault,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

    localparam int unsigned NSRC  = 56;
    localparam int unsigned SUM_W = DROP_CNT_W + 7;

    state_t                state_q, state_d;
    logic [NSRC-1:0]       prev_q, prev_d;
    logic [NSRC-1:0]       pending_q, pending_d;
    logic                  spi_prev_q, spi_prev_d;
    logic                  spi_pend_q, spi_pend_d;
    logic [5:0]            rr_ptr_q, rr_ptr_d;
    logic [5:0]            win_idx_q, win_idx_d;
    logic                  win_spi_q, win_spi_d;
    logic [7:0]            evt_data_q, evt_data_d;
    logic [6:0]            sticky_q, sticky_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic [NSRC-1:0]       in_vec, rise, win_mask, keep_mask, hs_mask;
    logic [NSRC:0]         hits;
    logic [6:0]            type_rise, hit_cnt, rr_sum;
    logic [5:0]            arb_idx, cand;
    logic                  arb_found, spi_rise, in_send, hs, spi_hs;
    logic [SUM_W-1:0]      drop_sum;

    // Flat index (type-1)*8 + board
    assign in_vec = {unexp_adc_trig_stable, unexp_dac_trig_stable,
                     adc_buf_overflow_stable, dac_buf_underflow_stable,
                     thresh_overflow_stable, thresh_underflow_stable,
                     over_thresh_stable};

    always_comb begin
        prev_d     = in_vec;
        spi_prev_d = spi_off_stable;
        rise       = in_vec & ~prev_q;
        spi_rise   = SPI_OFF_EVT && spi_off_stable && !spi_prev_q;
        type_rise  = '0;
        for (int unsigned t = 0; t < 7; t++) begin
            type_rise[t] = |rise[t*8 +: 8];
        end

        // First pending index at or above rr_ptr, wrapping 55 -> 0
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned j = 0; j < NSRC; j++) begin
            rr_sum = 7'(rr_ptr_q) + 7'(j);
            if (rr_sum >= 7'd56) begin
                rr_sum = rr_sum - 7'd56;
            end
            cand = rr_sum[5:0];
            if (!arb_found && pending_q[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end

        in_send   = (state_q == SEND);
        hs        = in_send && evt_ready;
        spi_hs    = hs && win_spi_q;
        win_mask  = (in_send && !win_spi_q) ? (56'd1 << win_idx_q) : '0;
        keep_mask = clr ? win_mask : '1;
        hs_mask   = hs ? win_mask : '0;

        // New rises are OR'd in last so they survive both clr and the handshake
        pending_d  = (pending_q & keep_mask & ~hs_mask) | rise;
        spi_pend_d = (spi_pend_q && (!clr || (in_send && win_spi_q)) && !spi_hs)
                     || spi_rise;

        hits    = {spi_rise && spi_pend_q && !spi_hs, rise & pending_q & ~hs_mask};
        hit_cnt = '0;
        for (int unsigned i = 0; i <= NSRC; i++) begin
            hit_cnt = hit_cnt + 7'(hits[i]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(hit_cnt);
        if (clr) begin
            drop_d = '0;
        end else if (drop_sum > SUM_W'({DROP_CNT_W{1'b1}})) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_CNT_W-1:0];
        end
        sticky_d = clr ? type_rise : (sticky_q | type_rise);

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_idx_d  = win_idx_q;
        win_spi_d  = win_spi_q;
        evt_data_d = evt_data_q;
        case (state_q)
            IDLE: begin
                if (|pending_q || spi_pend_q) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                // clr here wipes the candidate before it becomes the SEND winner
                if (clr) begin
                    state_d = IDLE;
                end else if (spi_pend_q) begin
                    win_spi_d  = 1'b1;
                    evt_data_d = 8'h00;
                    state_d    = SEND;
                end else if (arb_found) begin
                    win_spi_d  = 1'b0;
                    win_idx_d  = arb_idx;
                    evt_data_d = {arb_idx[5:3] + 3'd1, 2'b00, arb_idx[2:0]};
                    state_d    = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (hs) begin
                    if (!win_spi_q) begin
                        rr_ptr_d = (win_idx_q == 6'd55) ? '0 : win_idx_q + 6'd1;
                    end
                    state_d = (|pending_d || spi_pend_d) ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            pending_q  <= '0;
            spi_prev_q <= 1'b0;
            spi_pend_q <= 1'b0;
            rr_ptr_q   <= '0;
            win_idx_q  <= '0;
            win_spi_q  <= 1'b0;
            evt_data_q <= '0;
            sticky_q   <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            spi_prev_q <= spi_prev_d;
            spi_pend_q <= spi_pend_d;
            rr_ptr_q   <= rr_ptr_d;
            win_idx_q  <= win_idx_d;
            win_spi_q  <= win_spi_d;
            evt_data_q <= evt_data_d;
            sticky_q   <= sticky_d;
            drop_q     <= drop_d;
        end
    end

    assign evt_valid    = (state_q == SEND);
    assign evt_data     = evt_data_q;
    assign fault_sticky = sticky_q;
    assign any_fault    = |sticky_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_spi_sts_event_sched.sv
// Directed self-checking bench for spi_sts_event_sched.
module tb_spi_sts_event_sched;
    logic        aclk = 1'b0;
    logic        areset;
    logic        spi_off_stable;
    logic [7:0]  over_thresh_stable, thresh_underflow_stable, thresh_overflow_stable;
    logic [7:0]  dac_buf_underflow_stable, adc_buf_overflow_stable;
    logic [7:0]  unexp_dac_trig_stable, unexp_adc_trig_stable;
    logic        clr, evt_valid, evt_ready, any_fault;
    logic [7:0]  evt_data;
    logic [6:0]  fault_sticky;
    logic [15:0] drop_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 aclk = ~aclk;

    spi_sts_event_sched #(.DROP_CNT_W(16), .SPI_OFF_EVT(1'b1)) dut (
        .aclk(aclk), .areset(areset), .spi_off_stable(spi_off_stable),
        .over_thresh_stable(over_thresh_stable),
        .thresh_underflow_stable(thresh_underflow_stable),
        .thresh_overflow_stable(thresh_overflow_stable),
        .dac_buf_underflow_stable(dac_buf_underflow_stable),
        .adc_buf_overflow_stable(adc_buf_overflow_stable),
        .unexp_dac_trig_stable(unexp_dac_trig_stable),
        .unexp_adc_trig_stable(unexp_adc_trig_stable),
        .clr(clr), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .fault_sticky(fault_sticky),
        .any_fault(any_fault), .drop_cnt(drop_cnt)
    );

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        tests_run++; if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        tests_run++; if (evt_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", evt_data); end
        tests_run++; if (fault_sticky !== 7'h00) begin tests_failed++; $display("FAIL reset_sticky: got %h expected 00", fault_sticky); end
        tests_run++; if (any_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_any: got %b expected 0", any_fault); end
        tests_run++; if (drop_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_drop: got %h expected 0", drop_cnt); end
    endtask

    task automatic test_latency();
        areset = 1'b0;
        @(negedge aclk);
        tests_run++; if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_c0_valid: got %b expected 0", evt_valid); end
        tests_run++; if (fault_sticky !== 7'h01) begin tests_failed++; $display("FAIL lat_sticky: got %h expected 01", fault_sticky); end
        tests_run++; if (any_fault !== 1'b1) begin tests_failed++; $display("FAIL lat_any: got %b expected 1", any_fault); end
        @(negedge aclk);
        tests_run++; if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_c1_valid: got %b expected 0", evt_valid); end
        @(negedge aclk);
        tests_run++; if (evt_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_c2_valid: got %b expected 1", evt_valid); end
        tests_run++; if (evt_data !== 8'h20) begin tests_failed++; $display("FAIL lat_c2_data: got %h expected 20", evt_data); end
        evt_ready = 1'b1;
        @(negedge aclk);
        tests_run++; if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_after_hs: got %b expected 0", evt_valid); end
    endtask

    task automatic test_burst();
        int n = 0;
        int last = 0;
        int first = -1;
        logic [7:0] exp;
        evt_ready = 1'b1;
        adc_buf_overflow_stable = 8'hFF;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge aclk);
            if (evt_valid) begin
                exp = 8'hA0 + 8'(n);
                tests_run++; if (evt_data !== exp) begin tests_failed++; $display("FAIL burst_data[%0d]: got %h expected %h", n, evt_data, exp); end
                if (n == 0) first = cyc;
                else begin
                    tests_run++; if (cyc - last !== 2) begin tests_failed++; $display("FAIL burst_gap[%0d]: got %0d expected 2", n, cyc - last); end
                end
                last = cyc;
                n++;
            end
        end
        tests_run++; if (first !== 3) begin tests_failed++; $display("FAIL burst_first_cycle: got %0d expected 3", first); end
        tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL burst_count: got %0d expected 8", n); end
        tests_run++; if (fault_sticky !== 7'h11) begin tests_failed++; $display("FAIL burst_sticky: got %h expected 11", fault_sticky); end
    endtask

    task automatic test_backpressure();
        bit found = 0;
        int n = 0;
        logic [7:0] exp;
        adc_buf_overflow_stable = 8'h00;
        repeat (2) @(negedge aclk);
        adc_buf_overflow_stable = 8'hFF;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge aclk);
            if (evt_valid && evt_data == 8'hA3) begin
                evt_ready = 1'b0;
                found = 1;
                break;
            end
        end
        tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL bp_a3_seen: got %b expected 1", found); end
        tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL bp_drop_before: got %0d expected 0", drop_cnt); end
        for (int i = 0; i < 20; i++) begin
            if (i == 3) adc_buf_overflow_stable = 8'hF7;
            if (i == 5) adc_buf_overflow_stable = 8'hFF;
            @(negedge aclk);
            tests_run++;
            if (evt_valid !== 1'b1 || evt_data !== 8'hA3) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=a3", i, evt_valid, evt_data);
            end
        end
        tests_run++; if (drop_cnt !== 16'd1) begin tests_failed++; $display("FAIL bp_drop_after: got %0d expected 1", drop_cnt); end
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (evt_valid) begin
                exp = 8'hA3 + 8'(n);
                tests_run++; if (evt_data !== exp) begin tests_failed++; $display("FAIL bp_drain[%0d]: got %h expected %h", n, evt_data, exp); end
                n++;
            end
            @(negedge aclk);
        end
        tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL bp_drain_count: got %0d expected 5", n); end
        clr = 1'b1;
        @(negedge aclk);
        clr = 1'b0;
        tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL bp_clr_drop: got %0d expected 0", drop_cnt); end
        tests_run++; if (fault_sticky !== 7'h00) begin tests_failed++; $display("FAIL bp_clr_sticky: got %h expected 00", fault_sticky); end
    endtask

    task automatic test_spi_priority();
        int n = 0;
        logic [7:0] exp;
        evt_ready = 1'b1;
        spi_off_stable = 1'b1;
        unexp_adc_trig_stable = 8'h80;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge aclk);
            if (evt_valid) begin
                exp = (n == 0) ? 8'h00 : 8'hE7;
                tests_run++; if (evt_data !== exp) begin tests_failed++; $display("FAIL spi_order[%0d]: got %h expected %h", n, evt_data, exp); end
                n++;
            end
        end
        tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL spi_count: got %0d expected 2", n); end
        tests_run++; if (fault_sticky !== 7'h40) begin tests_failed++; $display("FAIL spi_sticky: got %h expected 40", fault_sticky); end
    endtask

    task automatic test_rr_wrap();
        int n = 0;
        logic [7:0] exp;
        unexp_adc_trig_stable = 8'h00;
        over_thresh_stable = 8'h00;
        repeat (2) @(negedge aclk);
        unexp_adc_trig_stable = 8'h40;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge aclk);
            if (evt_valid) begin
                tests_run++; if (evt_data !== 8'hE6) begin tests_failed++; $display("FAIL rr_setup: got %h expected e6", evt_data); end
                n++;
            end
        end
        tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL rr_setup_count: got %0d expected 1", n); end
        n = 0;
        unexp_adc_trig_stable = 8'hC0;
        over_thresh_stable = 8'h01;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge aclk);
            if (evt_valid) begin
                exp = (n == 0) ? 8'hE7 : 8'h20;
                tests_run++; if (evt_data !== exp) begin tests_failed++; $display("FAIL rr_wrap[%0d]: got %h expected %h", n, evt_data, exp); end
                n++;
            end
        end
        tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL rr_wrap_count: got %0d expected 2", n); end
    endtask

    task automatic test_clr();
        bit found = 0;
        int n = 0;
        evt_ready = 1'b0;
        thresh_underflow_stable = 8'h0F;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge aclk);
            if (evt_valid) begin
                found = 1;
                break;
            end
        end
        tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL clr_valid_seen: got %b expected 1", found); end
        tests_run++; if (evt_data !== 8'h40) begin tests_failed++; $display("FAIL clr_winner: got %h expected 40", evt_data); end
        clr = 1'b1;
        @(negedge aclk);
        clr = 1'b0;
        tests_run++; if (fault_sticky !== 7'h00) begin tests_failed++; $display("FAIL clr_sticky: got %h expected 00", fault_sticky); end
        tests_run++; if (any_fault !== 1'b0) begin tests_failed++; $display("FAIL clr_any: got %b expected 0", any_fault); end
        tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL clr_drop: got %0d expected 0", drop_cnt); end
        tests_run++; if (evt_valid !== 1'b1 || evt_data !== 8'h40) begin tests_failed++; $display("FAIL clr_inflight: got valid=%b data=%h expected valid=1 data=40", evt_valid, evt_data); end
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (evt_valid) begin
                tests_run++; if (evt_data !== 8'h40) begin tests_failed++; $display("FAIL clr_after[%0d]: got %h expected 40", n, evt_data); end
                n++;
            end
            @(negedge aclk);
        end
        tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL clr_event_count: got %0d expected 1", n); end
    endtask

    initial begin
        areset = 1'b1;
        spi_off_stable = 1'b0;
        over_thresh_stable = 8'h01;
        thresh_underflow_stable = 8'h00;
        thresh_overflow_stable = 8'h00;
        dac_buf_underflow_stable = 8'h00;
        adc_buf_overflow_stable = 8'h00;
        unexp_dac_trig_stable = 8'h00;
        unexp_adc_trig_stable = 8'h00;
        clr = 1'b0;
        evt_ready = 1'b0;
        test_reset();
        test_latency();
        test_burst();
        test_backpressure();
        test_spi_priority();
        test_rr_wrap();
        test_clr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
